// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch/button input conditioning blocks.
// No logic of its own; the decode helpers keep output meaning next to the state encoding.
// No flow control; pure declarations.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1000;

    // Debounced level is already 1 while a falling candidate is still being qualified.
    function automatic logic state_level(state_t s);
        return (s == ONE) || (s == WAIT0);
    endfunction

    function automatic logic state_busy(state_t s);
        return (s == WAIT1) || (s == WAIT0);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer bringing an asynchronous single-bit input into the core_clk domain.
// Latency: STAGES cycles from in_dat to out_dat.
// No backpressure; samples every cycle.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic in_dat,
    output logic out_dat
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_dat};
        end
    end

    assign out_dat = sync_q[STAGES-1];

endmodule

// File: rtl/level_debouncer.sv
// Synchronizes and debounces a raw switch input into a clean registered level.
// Latency: SYNC_STAGES cycles to busy, SYNC_STAGES+STABLE_CYCLES cycles to level.
// No backpressure; a new value must hold STABLE_CYCLES consecutive cycles to be accepted.
module level_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_in;
    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .core_clk (clk),
        .arst_n   (rst),
        .in_dat   (raw_in),
        .out_dat  (sync_in)
    );

    // Any disagreement during a WAIT state drops back; the count is reloaded on the next entry.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            ZERO: begin
                if (sync_in) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sync_in) begin
                    state_nxt = ZERO;
                end else if (cnt_q == '0) begin
                    state_nxt = ONE;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            ONE: begin
                if (!sync_in) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sync_in) begin
                    state_nxt = ONE;
                end else if (cnt_q == '0) begin
                    state_nxt = ZERO;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ZERO;
            end
        endcase
    end

    // Outputs are registered from the next state so they stay cycle-aligned with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            level   <= state_level(state_nxt);
            busy    <= state_busy(state_nxt);
        end
    end

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: STABLE_CYCLES=4 and STABLE_CYCLES=1 instances side by side,
// directed latency/bounce/reset scenarios plus random bouncing against a run-length model.
module tb_level_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] raw;
    logic [1:0] level_w;
    logic [1:0] busy_w;

    always #5 clk = ~clk;

    level_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw[0]),
        .level  (level_w[0]),
        .busy   (busy_w[0])
    );

    level_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (1)
    ) dut_s1 (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw[1]),
        .level  (level_w[1]),
        .busy   (busy_w[1])
    );

    // Model: sync_in is raw delayed two edges; level flips to sync_in once sync_in has
    // differed from level for STABLE+1 consecutive edges; busy means sync_in != level.
    typedef struct {
        bit [1:0] pipe;
        bit       lvl;
        bit       busy;
        bit       prev;
        int       run;
    } mstate_t;

    mstate_t m [2];
    int      n_checks = 0;
    int      n_pass   = 0;
    bit      cmp_en   = 1'b0;
    int      dut_rises [2];
    int      mdl_rises [2];
    bit      dut_prev  [2];
    bit      mdl_prev  [2];

    function automatic mstate_t reset_state();
        mstate_t r;
        r.pipe = 2'b00;
        r.lvl  = 1'b0;
        r.busy = 1'b0;
        r.prev = 1'b0;
        r.run  = 0;
        return r;
    endfunction

    function automatic mstate_t step(mstate_t cur, bit r, int stable);
        mstate_t nx;
        bit      s;
        nx = cur;
        s  = cur.pipe[1];
        if (s == cur.prev) nx.run = (cur.run < 1000) ? cur.run + 1 : cur.run;
        else               nx.run = 1;
        nx.prev = s;
        if (s != cur.lvl && nx.run >= stable + 1) nx.lvl = s;
        nx.busy = (s != nx.lvl);
        nx.pipe = {cur.pipe[0], r};
        return nx;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= reset_state();
            m[1] <= reset_state();
        end else begin
            m[0] <= step(m[0], raw[0], 4);
            m[1] <= step(m[1], raw[1], 1);
        end
    end

    task automatic check(string name, logic got, logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic check_int(string name, int got, int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("model_level[%0d]", j), level_w[j], m[j].lvl);
                check($sformatf("model_busy[%0d]", j), busy_w[j], m[j].busy);
                if (level_w[j] && !dut_prev[j]) dut_rises[j]++;
                if (m[j].lvl && !mdl_prev[j]) mdl_rises[j]++;
                dut_prev[j] = level_w[j];
                mdl_prev[j] = m[j].lvl;
            end
        end
    end

    task automatic settle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after raw[j] was driven to dir at a negedge; edge k is the next posedge.
    task automatic trans_lit(string tag, int j, int stable, bit dir);
        for (int i = 0; i <= stable + 3; i++) begin
            @(negedge clk);
            check($sformatf("%s_busy_e%0d", tag, i), busy_w[j], (i >= 2 && i <= stable + 1));
            check($sformatf("%s_level_e%0d", tag, i), level_w[j], (i >= stable + 2) ? dir : !dir);
        end
    endtask

    int hold [2];

    initial begin
        raw    = 2'b11;
        rst    = 1'b0;
        cmp_en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            dut_rises[j] = 0;
            mdl_rises[j] = 0;
            dut_prev[j]  = 1'b0;
            mdl_prev[j]  = 1'b0;
        end

        // Reset held with raw high: outputs stay low, then full latency after release.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_level", level_w[0], 1'b0);
            check("rst_busy", busy_w[0], 1'b0);
        end
        rst = 1'b1;
        trans_lit("rst_rise", 0, 4, 1'b1);

        // Two-cycle low glitch from level 1 is rejected.
        raw[0] = 1'b0;
        settle(2);
        raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("glitch_level", level_w[0], 1'b1);
        end
        check("glitch_busy_end", busy_w[0], 1'b0);

        raw[0] = 1'b0;
        trans_lit("fall", 0, 4, 1'b0);
        settle(3);

        raw[0] = 1'b1;
        trans_lit("rise", 0, 4, 1'b1);
        raw[0] = 1'b0;
        settle(10);

        // Bounce: high 3, low 1, high 2, then low.
        raw[0] = 1'b1; settle(3);
        raw[0] = 1'b0; settle(1);
        raw[0] = 1'b1; settle(2);
        raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bounce_level", level_w[0], 1'b0);
        end
        check("bounce_busy_end", busy_w[0], 1'b0);

        // Reset two cycles into WAIT1, then a full-latency rise afterwards.
        raw[0] = 1'b1;
        settle(3);
        check("wait1_busy", busy_w[0], 1'b1);
        settle(2);
        #2 rst = 1'b0;
        #1;
        check("midrst_level", level_w[0], 1'b0);
        check("midrst_busy", busy_w[0], 1'b0);
        check("midrst_level_s1", level_w[1], 1'b0);
        settle(2);
        rst = 1'b1;
        trans_lit("post_rst", 0, 4, 1'b1);

        // Minimal filter instance.
        raw[1] = 1'b0;
        settle(6);
        check("s1_low", level_w[1], 1'b0);
        raw[1] = 1'b1;
        trans_lit("s1_rise", 1, 1, 1'b1);
        raw[1] = 1'b0;
        settle(6);
        raw[1] = 1'b1;
        @(negedge clk);
        raw[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("s1_pulse_level", level_w[1], 1'b0);
        end

        // Random bouncing with occasional asynchronous resets.
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (hold[j] == 0) begin
                    raw[j]  = ~raw[j];
                    hold[j] = (j == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 4));
                end else begin
                    hold[j]--;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                #1;
                check("rand_rst_level", level_w[0], 1'b0);
                check("rand_rst_busy", busy_w[0], 1'b0);
                @(negedge clk);
                rst = 1'b1;
            end
        end
        settle(2);

        check_int("ticks_s4", dut_rises[0], mdl_rises[0]);
        check_int("ticks_s1", dut_rises[1], mdl_rises[1]);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/level_debouncer.md
# level_debouncer

Front-end conditioning stage placed directly upstream of `edgeDetector`. It synchronizes a raw, asynchronous, bouncing switch/button input into the `clk` domain and filters it. It outputs a clean `level` that changes only after the input has held a new value for a programmable number of consecutive cycles. `level` connects straight to `edgeDetector.level`, so `mealy_tick`/`moore_tick` fire once per real press.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal ≥2.
- `STABLE_CYCLES`, default 1000: consecutive cycles the synchronized input must hold before `level` follows it; legal ≥1.
- `CNT_W`, default `$clog2(STABLE_CYCLES)+1`: down-counter width; derived, not overridden.
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous and active-low (asserted at 0).
- `raw_in`  in  1: asynchronous raw switch input.
- `level`  out  1: debounced, synchronous level.
- `busy`  out  1: high while a candidate transition is being qualified.

## Operation
- `raw_in` passes through a `SYNC_STAGES`-deep flop chain. Its last stage is `sync_in`. Only `sync_in` is used downstream.
- The FSM has four states, and the counter `cnt` is CNT_W bits:
  - ZERO: `level`=0, `busy`=0. If `sync_in`=1, go to WAIT1 and load `cnt`=STABLE_CYCLES-1.
  - WAIT1: `level`=0, `busy`=1.
    - If `sync_in`=0, return to ZERO.
    - Else if `cnt`=0, go to ONE.
    - Else decrement `cnt`.
  - ONE: `level`=1, `busy`=0. If `sync_in`=0, go to WAIT0 and load `cnt`=STABLE_CYCLES-1.
  - WAIT0: `level`=1, `busy`=1.
    - If `sync_in`=1, return to ONE.
    - Else if `cnt`=0, go to ZERO.
    - Else decrement `cnt`.
- `level` and `busy` are Moore outputs decoded from state and registered, so they are glitch-free. No combinational path exists from `raw_in` to any output.
- Any glitch during WAIT1 or WAIT0 aborts the qualification. The counter restarts on the next entry; partial counts are never accumulated.
- `cnt` never underflows. It is only decremented when nonzero.

## Timing
- Reset (`rst`=0, asynchronous) puts every output and internal flop at a defined value:
  - all synchronizer flops = 0;
  - state = ZERO;
  - `cnt` = 0;
  - `level` = 0;
  - `busy` = 0.
- Release of `rst` takes effect at the next rising edge. Deassertion is assumed to be synchronized externally.
- If `raw_in` is held at 1 through reset, it is debounced normally after release, and `level` rises at the full latency.
- Rise latency: `raw_in` changes and is stable before edge k, then held.
  - `busy`=1 after edge k+SYNC_STAGES.
  - `level`=1 and `busy`=0 after edge k+SYNC_STAGES+STABLE_CYCLES.
- Fall latency is identical and symmetric.
- A pulse on `sync_in` shorter than STABLE_CYCLES cycles never changes `level`.
- With STABLE_CYCLES=1, WAIT lasts exactly one cycle.
- Reset asserted mid-WAIT1 or mid-WAIT0 immediately forces ZERO, `level`=0, `busy`=0, and clears partial progress.

## Structure
- Package `debounce_pkg` holds:
  - the `state_t` enum (ZERO, WAIT1, ONE, WAIT0), 2-bit binary encoding;
  - the default constants for SYNC_STAGES and STABLE_CYCLES.
- Sub-module `sync_chain` is a parameterized N-flop synchronizer with async active-low reset to 0. It is reused by later input blocks.
- The top level contains the FSM, `cnt`, and registered output decode.

## Test plan
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4, clk period 10 ns, unless noted.
- Reset behaviour: `rst`=0 with `raw_in`=1 for 5 cycles → `level`=0 and `busy`=0 throughout. After release, `level`=1 appears exactly 6 edges after the first sampling edge.
- Clean rise: `raw_in` 0→1 before edge k, held → `busy`=1 after edges k+2..k+5, `level`=1 after edge k+6, `busy`=0 from then on.
- Bounce rejection: `raw_in` high for 3 cycles, low 1, high 2, low held → `level` stays 0. `busy` pulses and ends at 0, and state is ZERO.
- Clean fall plus glitch:
  - from `level`=1, a 2-cycle low glitch → `level` stays 1;
  - a sustained low → `level`=0 six edges after it starts.
- Reset mid-qualification: `rst` asserted two cycles into WAIT1 → `level`=0 and `busy`=0 immediately. After release with `raw_in` still high, a full 6-edge latency is required before `level`=1.
- Minimal filter, STABLE_CYCLES=1: a rise held → `level`=1 after edge k+3. A 1-cycle `sync_in` pulse → no `level` change.
- System check: chain with `edgeDetector` → exactly one `moore_tick` per qualified rise, and none for rejected bounces.
